exec_unit: RTL
==============

EXEC_UNIT -- requirements
Module: exec_unit

Interface
REQ-001 SHALL expose ports in this order (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on its rising edge
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  upstream presents an operation
- in_ready  out  1  unit accepts an operation this cycle
- op  in  12  one-hot ALU function select, same encoding as the ALU f input; 12'h003 means multiply
- src_a  in  32  operand A, from register A
- src_b  in  32  operand B, from register B
- imm  in  32  extended immediate
- use_imm  in  1  1 selects imm as operand B, 0 selects src_b
- out_valid  out  1  result is available
- out_ready  in  1  downstream (ALUOut/writeback) takes the result
- result  out  32  registered result
REQ-002 SHALL have no parameters.

Function
REQ-003 SHALL implement an FSM with four states:
- IDLE: in_ready=1.
- EXEC: one cycle; captures the ALU output into result.
- MUL: iterative multiply.
- RESP: out_valid=1.
REQ-004 An accept (in_valid && in_ready at a clock edge) SHALL latch op, src_a and the selected B operand (use_imm ? imm : src_b) into internal registers.
REQ-005 After an accept, next state SHALL be MUL if op==12'h003 and MUL_EN is defined; otherwise EXEC.
REQ-006 Non-multiply latency: accept at edge N; result captured at edge N+1; out_valid=1 from edge N+1.
REQ-007 ALU result SHALL be computed combinationally from the latched registers only, never from live inputs.
REQ-008 ALU semantics for the supported codes:
- 001 and 002: add and subtract.
- 004: unsigned less-than (~carry).
- 008: signed less-than (sign of a-b, no overflow correction).
- 010 to 080: and, or, nor, xor.
- 100 to 400: sll, srl, sra by b[4:0].
- 800: pass b.
REQ-009 Any other op SHALL yield result=0, with normal non-multiply latency and no error flag.
REQ-010 In RESP, result and out_valid SHALL hold stable until out_ready=1.
REQ-011 in_ready SHALL be 1 in IDLE, and also in RESP when out_ready=1, so back-to-back accepts are possible.
REQ-012 RESP with out_ready=1 and in_valid=1: the new op SHALL be accepted, out_valid SHALL drop for exactly the EXEC/MUL cycles, and no result SHALL be lost or duplicated.
REQ-013 RESP with out_ready=1 and in_valid=0 SHALL return to IDLE.
REQ-014 in_ready SHALL be 0 in EXEC and in MUL.

Reset
REQ-015 rst_n=0 SHALL asynchronously force, from any state including mid-multiply:
- state to IDLE
- out_valid=0, result=0
- latched operands and op to 0
- multiply counter to 0
REQ-016 Once rst_n deasserts, the first accept SHALL be possible on the first clock edge.

Configuration
REQ-017 Macro EXEC_UNIT_MUL_EN defined: op 12'h003 SHALL run a shift-add multiply:
- 6-bit counter, one bit per cycle.
- 32 MUL cycles, then RESP.
- result = low 32 bits of a*b (unsigned product, identical to signed low word).
- Total latency accept-to-out_valid: 33 edges.
REQ-018 Macro undefined: no multiplier logic SHALL be present, and 12'h003 SHALL follow REQ-009 (result=0, latency 1).

Structure
REQ-019 Package exec_pkg SHALL hold:
- one-hot op localparams (OP_ADD to OP_LUI, OP_MUL=12'h003)
- state enum state_t
- MUL_CYCLES=32
REQ-020 The existing ALU module SHALL be instantiated once as the sole sub-module.
REQ-021 The multiplier SHALL be local logic inside exec_unit, guarded by the macro.

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- op=001, A=5, B=7, use_imm=0 -> result=12, out_valid one edge after accept.
- op=002, A=3, B=5 -> 0xFFFFFFFE.
- op=008, A=0xFFFFFFFF, B=1 -> 1.
- op=004, A=1, B=2 -> 1.
- op=100, A=1, imm=4, use_imm=1, src_b=0x1F -> 16 (imm selected).
- out_ready held 0 for 5 cycles -> result stable and in_ready=0 throughout; then out_ready=1 with in_valid=1 for op=080, A=0xF0, B=0xFF -> 0x0F delivered once, first result not repeated.
- With EXEC_UNIT_MUL_EN: op=003, A=7, B=6 -> 42 after 33 edges.
- Same MUL, rst_n pulsed low at MUL cycle 10 -> out_valid=0, result=0, in_ready=1 immediately.
- Without the macro: op=003 -> 0 after 1 edge.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared definitions for exec_unit: one-hot ALU op codes, FSM states, multiply length.
// Latency: n/a (definitions only). Backpressure: n/a.
// Op 12'h003 is multiply only when EXEC_UNIT_MUL_EN is defined.
package exec_pkg;

    localparam logic [11:0] OP_ADD  = 12'h001;
    localparam logic [11:0] OP_SUB  = 12'h002;
    localparam logic [11:0] OP_SLTU = 12'h004;
    localparam logic [11:0] OP_SLT  = 12'h008;
    localparam logic [11:0] OP_AND  = 12'h010;
    localparam logic [11:0] OP_OR   = 12'h020;
    localparam logic [11:0] OP_NOR  = 12'h040;
    localparam logic [11:0] OP_XOR  = 12'h080;
    localparam logic [11:0] OP_SLL  = 12'h100;
    localparam logic [11:0] OP_SRL  = 12'h200;
    localparam logic [11:0] OP_SRA  = 12'h400;
    localparam logic [11:0] OP_LUI  = 12'h800;
    localparam logic [11:0] OP_MUL  = 12'h003;

    localparam int MUL_CYCLES = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } state_t;

endpackage

// File: rtl/exec_unit_alu.sv
// Combinational 32-bit ALU with one-hot function select; unknown codes give 0.
// Latency: 0 cycles (pure combinational). Backpressure: none, no state.
// Never decodes 12'h003; multiply lives in exec_unit.
module exec_unit_alu
    import exec_pkg::*;
(
    input  logic [11:0] f,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] y
);

    // a + ~b + 1: bit 32 is the carry out, so ~carry means a < b unsigned
    logic [32:0] diff;
    assign diff = {1'b0, a} + {1'b0, ~b} + 33'd1;

    always_comb begin
        y = '0;
        case (f)
            OP_ADD:  y = a + b;
            OP_SUB:  y = diff[31:0];
            OP_SLTU: y = {31'd0, ~diff[32]};
            OP_SLT:  y = {31'd0, diff[31]};
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_NOR:  y = ~(a | b);
            OP_XOR:  y = a ^ b;
            OP_SLL:  y = a << b[4:0];
            OP_SRL:  y = a >> b[4:0];
            OP_SRA:  y = $signed(a) >>> b[4:0];
            OP_LUI:  y = b;
            default: y = '0;
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// Execution unit: latches one op, runs the ALU (or a shift-add multiply with EXEC_UNIT_MUL_EN), holds the result.
// Latency: 1 edge accept-to-out_valid for ALU ops; 33 edges for multiply when EXEC_UNIT_MUL_EN is defined.
// Backpressure: result/out_valid held until out_ready; a new op may be accepted in the same cycle the result leaves.
module exec_unit
    import exec_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [11:0] op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] imm,
    input  logic        use_imm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result
);

    state_t      state_q, state_d;
    logic [11:0] op_q, op_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] result_q, result_d;
    logic [31:0] alu_y;
    logic        accept;
`ifdef EXEC_UNIT_MUL_EN
    logic [5:0]  cnt_q, cnt_d;
`endif

    exec_unit_alu u_alu (
        .f (op_q),
        .a (a_q),
        .b (b_q),
        .y (alu_y)
    );

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_RESP) && out_ready);
    assign out_valid = (state_q == ST_RESP);
    assign result    = result_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        result_d = result_q;
`ifdef EXEC_UNIT_MUL_EN
        cnt_d    = cnt_q;
`endif
        if (accept) begin
            op_d    = op;
            a_d     = src_a;
            b_d     = use_imm ? imm : src_b;
            state_d = ST_EXEC;
`ifdef EXEC_UNIT_MUL_EN
            if (op == OP_MUL) begin
                state_d  = ST_MUL;
                cnt_d    = '0;
                result_d = '0;
            end
`endif
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_IDLE;
                ST_EXEC: begin
                    result_d = alu_y;
                    state_d  = ST_RESP;
                end
`ifdef EXEC_UNIT_MUL_EN
                // result accumulates partial products; a/b shift one bit per cycle
                ST_MUL: begin
                    if (cnt_q == 6'(MUL_CYCLES)) begin
                        state_d = ST_RESP;
                    end else begin
                        if (b_q[0]) begin
                            result_d = result_q + a_q;
                        end
                        a_d   = a_q << 1;
                        b_d   = b_q >> 1;
                        cnt_d = cnt_q + 6'd1;
                    end
                end
`endif
                ST_RESP: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
`ifdef EXEC_UNIT_MUL_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            result_q <= result_d;
`ifdef EXEC_UNIT_MUL_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

endmodule
